// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if
// Request/result bundle between a requesting datapath (master) and the
// bit-serial adder controller (slave).
//   start_in   : request strobe, sampled by the controller only when idle
//   a_in/b_in  : WIDTH-bit operands, captured on the accepted start
//   c_in       : carry-in, captured on the accepted start
//   busy_out   : controller is running or presenting a result
//   done_out   : one-cycle completion pulse
//   sum_out    : registered WIDTH-bit sum of the last completed operation
//   carry_out  : registered carry-out of the last completed operation
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;

    modport master (
        output start_in, a_in, b_in, c_in,
        input  busy_out, done_out, sum_out, carry_out
    );

    modport slave (
        input  start_in, a_in, b_in, c_in,
        output busy_out, done_out, sum_out, carry_out
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// full_adder
// 1-bit full adder cell shared by the serial adder controller.
//   a, b, cin : addend bits and carry-in
//   s, cout   : sum bit and carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// serial_adder_ctrl
// Bit-serial WIDTH-bit adder: one full_adder cell is fed LSB-first, one bit
// per clock, with the carry held in a register between bits. The finished
// WIDTH-bit sum and carry-out are registered and flagged by a one-cycle
// done pulse. Latency WIDTH cycles, one operation per WIDTH+2 cycles.
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : request/result bundle (slave side), see serial_adder_ctrl_if
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_adder_ctrl_if.slave   bus
);
    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             carry_out_q, carry_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic fa_s;
    logic fa_co;

    full_adder u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        sum_sr_d    = sum_sr_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_out_d   = sum_out_q;
        carry_out_d = carry_out_q;

        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    a_sr_d  = bus.a_in;
                    b_sr_d  = bus.b_in;
                    carry_d = bus.c_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // New sum bit enters at the MSB; after WIDTH shifts bit 0
                // of the result has reached position 0.
                sum_sr_d = (sum_sr_q >> 1) | {fa_s, {(WIDTH-1){1'b0}}};
                carry_d  = fa_co;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_out_d   = sum_sr_d;
                    carry_out_d = fa_co;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state so they
        // line up with the state they describe.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_out_q   <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_out_q   <= sum_out_d;
            carry_out_q <= carry_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy_out  = busy_q;
    assign bus.done_out  = done_q;
    assign bus.sum_out   = sum_out_q;
    assign bus.carry_out = carry_out_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
// Scoreboard bench for serial_adder_ctrl at WIDTH=8. The driver pushes the
// expected {carry, sum} and the accept cycle per issued operation; the
// monitor pops on every done pulse and checks result and latency, and
// checks that the registered result holds between completions.
module tb_serial_adder_ctrl;
    localparam int unsigned W = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W:0] res;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   cyc         = 0;
    int   total       = 0;
    int   passed      = 0;
    int   done_seen   = 0;
    logic rst_at_edge = 1'b1;

    always @(posedge clock) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor
    initial begin : monitor
        logic [W:0] last;
        bit         prev_done;
        exp_t       e;
        last      = '0;
        prev_done = 1'b0;
        forever begin
            @(negedge clock);
            if (rst_at_edge) begin
                last      = '0;
                prev_done = 1'b0;
            end
            if (bus.done_out === 1'b1) begin
                check("done_single_cycle", 64'(prev_done), 64'd0);
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", 64'({bus.carry_out, bus.sum_out}), 64'(e.res));
                    check("latency", 64'(cyc - e.acc), 64'(W));
                    last = e.res;
                end
                prev_done = 1'b1;
                done_seen++;
            end else begin
                check("hold", 64'({bus.carry_out, bus.sum_out}), 64'(last));
                prev_done = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy_out !== 1'b0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (bus.busy_out !== 1'b0) check("idle_timeout", 64'(bus.busy_out), 64'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [W:0] exp);
        wait_idle();
        bus.start_in = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.c_in     = c;
        sb.push_back('{res: exp, acc: cyc + 1});
        @(negedge clock);
        // Scramble inputs after capture; they must not affect the result.
        bus.start_in = 1'b0;
        bus.a_in     = ~a;
        bus.b_in     = a ^ b;
        bus.c_in     = ~c;
        wait_drain();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [W-1:0] ta [3];
        logic [W-1:0] tb_ [3];
        logic         tc [3];
        logic [W:0]   te [3];
        int           d0;
        logic [W-1:0] ra, rb;
        logic         rc;

        bus.start_in = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.c_in     = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Idle after reset: nothing moves.
        repeat (5) begin
            @(negedge clock);
            check("idle_busy", 64'(bus.busy_out), 64'd0);
        end
        check("idle_done", 64'(bus.done_out), 64'd0);
        check("idle_sum", 64'(bus.sum_out), 64'd0);
        check("idle_carry", 64'(bus.carry_out), 64'd0);
        check("idle_no_done", 64'(done_seen), 64'd0);

        // Directed vectors.
        run_op(8'h12, 8'h34, 1'b0, 9'h046);
        run_op(8'hFF, 8'h01, 1'b0, 9'h100);
        run_op(8'hA5, 8'h5A, 1'b1, 9'h100);
        run_op(8'h00, 8'h00, 1'b0, 9'h000);
        run_op(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        run_op(8'h80, 8'h7F, 1'b0, 9'h0FF);

        // start_in held high, operands changing every cycle.
        ta[0] = 8'h80; tb_[0] = 8'h80; tc[0] = 1'b0; te[0] = 9'h100;
        ta[1] = 8'h7F; tb_[1] = 8'h01; tc[1] = 1'b1; te[1] = 9'h081;
        ta[2] = 8'hC3; tb_[2] = 8'h3C; tc[2] = 1'b1; te[2] = 9'h100;
        wait_idle();
        bus.start_in = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k % 10 == 0) begin
                bus.a_in = ta[k/10];
                bus.b_in = tb_[k/10];
                bus.c_in = tc[k/10];
                sb.push_back('{res: te[k/10], acc: cyc + 1});
                if (k > 0) check("gap_busy_low", 64'(bus.busy_out), 64'd0);
            end else begin
                bus.a_in = 8'(k * 17);
                bus.b_in = ~8'(k * 5);
                bus.c_in = k[0];
                if (k % 10 == 9) check("done_cycle_busy", 64'(bus.busy_out), 64'd1);
            end
            @(negedge clock);
        end
        bus.start_in = 1'b0;
        wait_drain();

        // Reset mid-operation aborts without a done pulse.
        wait_idle();
        bus.start_in = 1'b1;
        bus.a_in     = 8'h0F;
        bus.b_in     = 8'h0F;
        bus.c_in     = 1'b0;
        d0 = done_seen;
        @(negedge clock);
        bus.start_in = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", 64'(bus.busy_out), 64'd0);
        check("abort_done", 64'(bus.done_out), 64'd0);
        check("abort_sum", 64'(bus.sum_out), 64'd0);
        check("abort_carry", 64'(bus.carry_out), 64'd0);
        repeat (12) @(negedge clock);
        check("abort_no_done", 64'(done_seen), 64'(d0));
        check("abort_idle", 64'(bus.busy_out), 64'd0);
        run_op(8'h03, 8'h04, 1'b1, 9'h008);

        // Random operands against exact addition.
        for (int i = 0; i < 2000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            run_op(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
        end

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
